// File: rtl/dmem_arb_pkg.sv
// Shared state encoding and sizing for the data-memory arbiter.
// LOCK_* constants are consumed only when DMEM_ARB_LOCK_EN is defined.
package dmem_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } dmem_state_e;

   localparam int unsigned DMEM_ADDR_W = 8;
   localparam int unsigned DMEM_DATA_W = 64;
   localparam logic [DMEM_ADDR_W-1:0] DMEM_IO_ADDR = 8'hFF;

   localparam int unsigned LOCK_MAX   = 16;
   localparam int unsigned LOCK_CNT_W = $clog2(LOCK_MAX + 1);

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-requester request/response bundle for dmem_arbiter; req_lock exists only
// when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = dmem_arb_pkg::DMEM_ADDR_W,
   parameter int unsigned DATA_W = dmem_arb_pkg::DMEM_DATA_W
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_we;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                io_write;
   logic [DATA_W-1:0]   io_data;

`ifdef DMEM_ARB_LOCK_EN
   logic [1:0]          req_lock;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_lock,
      input  req_ready, rsp_valid, rsp_rdata, io_write, io_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_lock,
      output req_ready, rsp_valid, rsp_rdata, io_write, io_data
   );
`else
   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, io_write, io_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, io_write, io_data
   );
`endif

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, read-first; rdata is registered one cycle after addr.
// No backpressure; the array itself is never reset.
module dmem_ram
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DATA_W = DMEM_DATA_W
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter over a zero-swept data memory with IO-address mirror;
// responses/io strobe 1 cycle after accept, ready held low during the sweep (DMEM_ARB_LOCK_EN adds grant lock).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned       ADDR_W  = DMEM_ADDR_W,
   parameter int unsigned       DATA_W  = DMEM_DATA_W,
   parameter logic [ADDR_W-1:0] IO_ADDR = DMEM_IO_ADDR
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_req_i,
   output logic          init_done_o,
   dmem_arbiter_if.slave bus_io
);

   dmem_state_e         state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                init_done_q, init_done_d;
   logic                rr_q, rr_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic                rd_pend_q, rd_pend_d;
   logic                io_write_q, io_write_d;
   logic [DATA_W-1:0]   io_data_q, io_data_d;

   logic [1:0]          vld;
   logic                win;
   logic [1:0]          grant;
   logic                accept;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                io_hit;

   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;

   assign vld = bus_io.req_valid;

`ifdef DMEM_ARB_LOCK_EN
   logic                  acc_last_q, acc_last_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic                  lock_hit;

   // rr_q doubles as "last accepted port"; acc_last_q says it was last cycle.
   assign lock_hit = acc_last_q & vld[rr_q] & bus_io.req_lock[rr_q]
                   & (lock_cnt_q < LOCK_CNT_W'(LOCK_MAX));
`endif

   always_comb begin
      win = vld[1] & (~vld[0] | ~rr_q);
`ifdef DMEM_ARB_LOCK_EN
      if (lock_hit) begin
         win = rr_q;
      end
`endif
      grant = 2'b00;
      if (state_q == ST_RUN && vld != 2'b00) begin
         grant = port_onehot(win);
      end
   end

   assign accept    = |grant;
   assign sel_we    = win ? bus_io.req_we[1] : bus_io.req_we[0];
   assign sel_addr  = win ? bus_io.req_addr[2*ADDR_W-1:ADDR_W]
                          : bus_io.req_addr[ADDR_W-1:0];
   assign sel_wdata = win ? bus_io.req_wdata[2*DATA_W-1:DATA_W]
                          : bus_io.req_wdata[DATA_W-1:0];
   assign io_hit    = accept & sel_we & (sel_addr == IO_ADDR);

   // The sweep owns the RAM port in INIT; ready is low there so nothing competes.
   assign ram_we    = (state_q == ST_INIT) | (accept & sel_we);
   assign ram_addr  = (state_q == ST_INIT) ? cnt_q : sel_addr;
   assign ram_wdata = (state_q == ST_INIT) ? '0 : sel_wdata;

   dmem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      rr_d        = rr_q;
      rsp_valid_d = grant;
      rd_pend_d   = accept & ~sel_we;
      io_write_d  = io_hit;
      io_data_d   = io_hit ? sel_wdata : '0;

      if (accept) begin
         rr_d = win;
      end

      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (clr_req_i) begin
               cnt_d = '0;
            end else if (cnt_q == '1) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         ST_RUN: begin
            // A transaction accepted alongside clr_req still completes.
            if (clr_req_i) begin
               state_d     = ST_INIT;
               cnt_d       = '0;
               init_done_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef DMEM_ARB_LOCK_EN
   always_comb begin
      acc_last_d = accept;
      lock_cnt_d = lock_cnt_q;
      if (accept) begin
         if (acc_last_q && (win == rr_q)) begin
            if (lock_cnt_q != LOCK_CNT_W'(LOCK_MAX)) begin
               lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
            end
         end else begin
            lock_cnt_d = LOCK_CNT_W'(1);
         end
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         rr_q        <= 1'b1;
         rsp_valid_q <= 2'b00;
         rd_pend_q   <= 1'b0;
         io_write_q  <= 1'b0;
         io_data_q   <= '0;
`ifdef DMEM_ARB_LOCK_EN
         acc_last_q  <= 1'b0;
         lock_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         rr_q        <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rd_pend_q   <= rd_pend_d;
         io_write_q  <= io_write_d;
         io_data_q   <= io_data_d;
`ifdef DMEM_ARB_LOCK_EN
         acc_last_q  <= acc_last_d;
         lock_cnt_q  <= lock_cnt_d;
`endif
      end
   end

   assign init_done_o      = init_done_q;
   assign bus_io.req_ready = grant;
   assign bus_io.rsp_valid = rsp_valid_q;
   assign bus_io.rsp_rdata = rd_pend_q ? ram_rdata : '0;
   assign bus_io.io_write  = io_write_q;
   assign bus_io.io_data   = io_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a transaction-level reference model.
// Lock behaviour is exercised when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic clk       = 1'b0;
   logic rst_n     = 1'b1;
   logic clr_req   = 1'b0;
   logic init_done;

   dmem_arbiter_if bus_if ();

   dmem_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clr_req_i   (clr_req),
      .init_done_o (init_done),
      .bus_io      (bus_if)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] ref_mem [256];
   int          init_left;
   logic        last_port;
   logic [1:0]  exp_rv;
   logic [63:0] exp_rd;
   logic        exp_iow;
   logic [63:0] exp_iod;
`ifdef DMEM_ARB_LOCK_EN
   logic        acc_prev;
   int unsigned streak;
   logic [1:0]  lock_drv;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      foreach (ref_mem[i]) ref_mem[i] = 64'h0;
   endtask

   // One clock: check last edge's responses, drive, check ready, advance the model.
   task automatic step(input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic clr);
      logic [1:0]  exp_ready;
      logic        w;
      logic [7:0]  a;
      logic [63:0] d;
      logic [1:0]  n_rv;
      logic [63:0] n_rd;
      logic        n_iow;
      logic [63:0] n_iod;

      chk("init_done", 64'(init_done), 64'(init_left == 0));
      chk("rsp_valid", 64'(bus_if.rsp_valid), 64'(exp_rv));
      chk("rsp_rdata", bus_if.rsp_rdata, exp_rd);
      chk("io_write", 64'(bus_if.io_write), 64'(exp_iow));
      chk("io_data", bus_if.io_data, exp_iod);

      bus_if.req_valid = v;
      bus_if.req_we    = we;
      bus_if.req_addr  = {a1, a0};
      bus_if.req_wdata = {d1, d0};
      clr_req          = clr;
`ifdef DMEM_ARB_LOCK_EN
      bus_if.req_lock  = lock_drv;
`endif
      #1;

      exp_ready = 2'b00;
      n_rv = 2'b00; n_rd = 64'h0; n_iow = 1'b0; n_iod = 64'h0;
      if (init_left == 0) begin
         w = (v == 2'b11) ? ~last_port : v[1];
`ifdef DMEM_ARB_LOCK_EN
         if (acc_prev && v[last_port] && lock_drv[last_port] && streak < LOCK_MAX) w = last_port;
`endif
         if (v != 2'b00) begin
            exp_ready = w ? 2'b10 : 2'b01;
            n_rv      = exp_ready;
            a = w ? a1 : a0;
            d = w ? d1 : d0;
            if (we[w]) begin
               ref_mem[a] = d;
               if (a == 8'hFF) begin
                  n_iow = 1'b1;
                  n_iod = d;
               end
            end else begin
               n_rd = ref_mem[a];
            end
`ifdef DMEM_ARB_LOCK_EN
            if (acc_prev && w == last_port) streak = (streak < LOCK_MAX) ? streak + 1 : streak;
            else streak = 1;
`endif
            last_port = w;
         end
`ifdef DMEM_ARB_LOCK_EN
         acc_prev = (v != 2'b00);
`endif
         if (clr) begin
            init_left = 256;
            clear_model();
         end
      end else begin
         init_left--;
         if (clr) init_left = 256;
`ifdef DMEM_ARB_LOCK_EN
         acc_prev = 1'b0;
`endif
      end
      chk("req_ready", 64'(bus_if.req_ready), 64'(exp_ready));

      @(posedge clk);
      @(negedge clk);
      exp_rv  = n_rv;
      exp_rd  = n_rd;
      exp_iow = n_iow;
      exp_iod = n_iod;
   endtask

   task automatic idle();
      step(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      clr_req          = 1'b0;
      bus_if.req_valid = 2'b11;
      bus_if.req_we    = 2'b11;
      bus_if.req_addr  = {8'hFF, 8'hFF};
      bus_if.req_wdata = {64'h1, 64'h2};
      #1;
      chk("rst_req_ready", 64'(bus_if.req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'h0);
      chk("rst_rsp_rdata", bus_if.rsp_rdata, 64'h0);
      chk("rst_io_write", 64'(bus_if.io_write), 64'h0);
      chk("rst_io_data", bus_if.io_data, 64'h0);
      chk("rst_init_done", 64'(init_done), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      init_left = 256;
      last_port = 1'b1;
      exp_rv = 2'b00; exp_rd = 64'h0; exp_iow = 1'b0; exp_iod = 64'h0;
      clear_model();
`ifdef DMEM_ARB_LOCK_EN
      acc_prev = 1'b0;
      streak   = 0;
`endif
   endtask

   initial begin
      bus_if.req_valid = 2'b00;
      bus_if.req_we    = 2'b00;
      bus_if.req_addr  = 16'h0;
      bus_if.req_wdata = 128'h0;
`ifdef DMEM_ARB_LOCK_EN
      lock_drv        = 2'b00;
      bus_if.req_lock = 2'b00;
`endif
      #2;
      do_reset();

      // Sweep with both ports pending, including a held-off write to the IO address.
      repeat (256) step(2'b11, 2'b10, 8'h10, 8'hFF, 64'h0, 64'h99, 1'b0);
      step(2'b11, 2'b00, 8'h10, 8'h10, 64'h0, 64'h0, 1'b0);
      idle();

      // Write then read-back on port 0.
      step(2'b01, 2'b01, 8'h05, 8'h00, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0);
      step(2'b01, 2'b00, 8'h05, 8'h00, 64'h0, 64'h0, 1'b0);
      idle();

      // Port 1 goes first so the contested burst starts with port 0.
      step(2'b10, 2'b00, 8'h00, 8'h05, 64'h0, 64'h0, 1'b0);
      repeat (6) step(2'b11, 2'b00, 8'h05, 8'h10, 64'h0, 64'h0, 1'b0);
      idle();

      // IO mirror: one pulse for 0xFF, none for 0xFE.
      step(2'b10, 2'b10, 8'h00, 8'hFF, 64'h0, 64'h42, 1'b0);
      idle();
      idle();
      step(2'b10, 2'b10, 8'h00, 8'hFE, 64'h0, 64'h43, 1'b0);
      idle();
      idle();

      // clr_req with a read accepted in the same cycle, then re-read after the sweep.
      step(2'b01, 2'b01, 8'h20, 8'h00, 64'h7, 64'h0, 1'b0);
      step(2'b01, 2'b00, 8'h20, 8'h00, 64'h0, 64'h0, 1'b1);
      repeat (100) step(2'b11, 2'b11, 8'hFF, 8'h20, 64'h5, 64'h6, 1'b0);
      step(2'b11, 2'b11, 8'hFF, 8'h20, 64'h5, 64'h6, 1'b1);
      repeat (256) step(2'b11, 2'b11, 8'hFF, 8'h20, 64'h5, 64'h6, 1'b0);
      step(2'b01, 2'b00, 8'h20, 8'h00, 64'h0, 64'h0, 1'b0);
      idle();

      // Reset with a response in flight, then again mid-sweep.
      step(2'b01, 2'b00, 8'h05, 8'h00, 64'h0, 64'h0, 1'b0);
      do_reset();
      repeat (100) idle();
      do_reset();
      repeat (256) idle();
      step(2'b01, 2'b00, 8'h05, 8'h00, 64'h0, 64'h0, 1'b0);
      idle();

`ifdef DMEM_ARB_LOCK_EN
      // Port 0 locked and streaming against port 1: 16 grants, then port 1.
      step(2'b10, 2'b00, 8'h00, 8'h01, 64'h0, 64'h0, 1'b0);
      lock_drv = 2'b01;
      repeat (18) step(2'b11, 2'b00, 8'h01, 8'h02, 64'h0, 64'h0, 1'b0);
      lock_drv = 2'b00;
      idle();
`endif

      for (int i = 0; i < 400; i++) begin
         logic [7:0] ra0;
         logic [7:0] ra1;
         ra0 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
         ra1 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
`ifdef DMEM_ARB_LOCK_EN
         lock_drv = 2'($urandom);
`endif
         step(2'($urandom), 2'($urandom), ra0, ra1,
              {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
